// File: rtl/regfile_ctrl_pkg.sv
// Shared defaults and types for the register-file writeback arbiter slice.
package regfile_ctrl_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int REG_AW_DEF       = 5;
  localparam int STARVE_LIMIT_DEF = 4;

  // STARVE_LIMIT is bounded to 1..15, so four bits always hold the wait count.
  localparam int WAIT_W = 4;

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Issue, writeback ports A/B and register-file write port bundle.
interface regfile_wb_arbiter_if import regfile_ctrl_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) ();

  logic              iss_valid;
  logic [REG_AW-1:0] iss_rs1;
  logic [REG_AW-1:0] iss_rs2;
  logic [REG_AW-1:0] iss_rd;
  logic              iss_long;
  logic              iss_stall;

  logic              a_valid;
  logic              a_ready;
  logic [REG_AW-1:0] a_rd;
  logic [XLEN-1:0]   a_data;

  logic              b_valid;
  logic              b_ready;
  logic [REG_AW-1:0] b_rd;
  logic [XLEN-1:0]   b_data;

  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wd;
  logic [REG_AW:0]   busy_cnt;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  iss_stall, a_ready, b_ready,
    input  rf_we, rf_rd, rf_wd, busy_cnt
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output iss_stall, a_ready, b_ready,
    output rf_we, rf_rd, rf_wd, busy_cnt
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Busy vector of registers awaiting a long-latency writeback, with issue hazard detect.
module wb_scoreboard import regfile_ctrl_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid_i,
  input  logic [REG_AW-1:0] iss_rs1_i,
  input  logic [REG_AW-1:0] iss_rs2_i,
  input  logic [REG_AW-1:0] iss_rd_i,
  input  logic              iss_long_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_idx_i,
  output logic              iss_stall_o,
  output logic [REG_AW:0]   busy_cnt_o
);

  localparam int NREG = 2**REG_AW;
  localparam int CW   = REG_AW + 1;

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            set_en;

  // Hazard looks only at registered busy, so a clear releases the stall one cycle later.
  assign iss_stall_o = iss_valid_i &&
                       (busy_q[iss_rs1_i] || busy_q[iss_rs2_i] || busy_q[iss_rd_i]);
  assign set_en      = iss_valid_i && !iss_stall_o && iss_long_i && (iss_rd_i != '0);

  assign busy_d[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      assign busy_d[gi] = (set_en && (iss_rd_i == REG_AW'(gi))) ||
                          (busy_q[gi] && !(clr_en_i && (clr_idx_i == REG_AW'(gi))));
    end
  endgenerate

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (A) and long-latency (B) writeback,
// with starvation override for B and a RAW/WAW scoreboard for issue.
module regfile_wb_arbiter import regfile_ctrl_pkg::*; #(
  parameter int XLEN         = XLEN_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve;
  logic              a_hs, b_hs;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_wd_q, rf_wd_d;

  // Neither ready depends on its own valid; the two readies never both grant a pair of valids.
  assign starve      = (wait_q >= WAIT_W'(STARVE_LIMIT));
  assign bus.a_ready = !(bus.b_valid && starve);
  assign bus.b_ready = !bus.a_valid || starve;
  assign a_hs        = bus.a_valid && bus.a_ready;
  assign b_hs        = bus.b_valid && bus.b_ready;

  always_comb begin
    wait_d = wait_q;
    if (!bus.b_valid || b_hs) begin
      wait_d = '0;
    end else if (wait_q < WAIT_W'(STARVE_LIMIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // x0 writes are accepted and latched but never enabled.
  always_comb begin
    rf_we_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    if (a_hs) begin
      rf_we_d = (bus.a_rd != '0);
      rf_rd_d = bus.a_rd;
      rf_wd_d = bus.a_data;
    end else if (b_hs) begin
      rf_we_d = (bus.b_rd != '0);
      rf_rd_d = bus.b_rd;
      rf_wd_d = bus.b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q  <= '0;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
    end else begin
      wait_q  <= wait_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign bus.rf_we = rf_we_q;
  assign bus.rf_rd = rf_rd_q;
  assign bus.rf_wd = rf_wd_q;

  wb_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid_i (bus.iss_valid),
    .iss_rs1_i   (bus.iss_rs1),
    .iss_rs2_i   (bus.iss_rs2),
    .iss_rd_i    (bus.iss_rd),
    .iss_long_i  (bus.iss_long),
    .clr_en_i    (b_hs),
    .clr_idx_i   (bus.b_rd),
    .iss_stall_o (bus.iss_stall),
    .busy_cnt_o  (bus.busy_cnt)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: the driver predicts each write into a queue, a monitor pops on every cycle.
module tb_regfile_wb_arbiter;
  import regfile_ctrl_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int LIMIT  = 4;
  localparam int NREG   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  regfile_wb_arbiter #(
    .XLEN         (XLEN),
    .REG_AW       (REG_AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic        we;
    reg_addr_t   rd;
    logic [31:0] wd;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          busy_m[NREG];
  int          refused;
  reg_addr_t   last_rd;
  logic [31:0] last_wd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int busy_count();
    int n = 0;
    foreach (busy_m[i]) n += int'(busy_m[i]);
    return n;
  endfunction

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    refused = 0;
    exp_q.delete();
    last_rd = '0;
    last_wd = '0;
  endtask

  task automatic drive_idle();
    bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0;
    bus.iss_long  = 1'b0;
    bus.a_valid   = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid   = 1'b0; bus.b_rd = '0; bus.b_data = '0;
  endtask

  // One cycle: drive after the rising edge, check combinational outputs and predict at the falling edge.
  task automatic step(input int iv, input int rs1, input int rs2, input int rd, input int lng,
                      input int av, input int ard, input logic [31:0] adat,
                      input int bv, input int brd, input logic [31:0] bdat);
    bit starve, stall_e, ar_e, br_e, a_hs, b_hs;
    @(posedge clk);
    #1;
    bus.iss_valid = (iv != 0);
    bus.iss_rs1   = reg_addr_t'(rs1);
    bus.iss_rs2   = reg_addr_t'(rs2);
    bus.iss_rd    = reg_addr_t'(rd);
    bus.iss_long  = (lng != 0);
    bus.a_valid   = (av != 0);
    bus.a_rd      = reg_addr_t'(ard);
    bus.a_data    = adat;
    bus.b_valid   = (bv != 0);
    bus.b_rd      = reg_addr_t'(brd);
    bus.b_data    = bdat;
    @(negedge clk);
    starve  = (refused >= LIMIT);
    stall_e = (iv != 0) && (busy_m[rs1 % NREG] || busy_m[rs2 % NREG] || busy_m[rd % NREG]);
    ar_e    = !((bv != 0) && starve);
    br_e    = (av == 0) || starve;
    chk("iss_stall", 32'(bus.iss_stall), 32'(stall_e));
    chk("a_ready",   32'(bus.a_ready),   32'(ar_e));
    chk("b_ready",   32'(bus.b_ready),   32'(br_e));
    chk("busy_cnt",  32'(bus.busy_cnt),  32'(busy_count()));
    a_hs = (av != 0) && ar_e;
    b_hs = (bv != 0) && br_e;
    if (a_hs)      exp_q.push_back('{cyc + 1, (ard % NREG) != 0, reg_addr_t'(ard), adat});
    else if (b_hs) exp_q.push_back('{cyc + 1, (brd % NREG) != 0, reg_addr_t'(brd), bdat});
    if ((bv == 0) || b_hs)  refused = 0;
    else if (refused < LIMIT) refused++;
    if (b_hs) busy_m[brd % NREG] = 1'b0;
    if ((iv != 0) && !stall_e && (lng != 0) && ((rd % NREG) != 0)) busy_m[rd % NREG] = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0);
  endtask

  // Write-port monitor: every out-of-reset cycle either matches the queue head or shows a held, disabled port.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("write_missed_cycle", 32'(exp_q[0].cyc), 32'(cyc));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("rf_we", 32'(bus.rf_we), 32'(e.we));
        chk("rf_rd", 32'(bus.rf_rd), 32'(e.rd));
        chk("rf_wd", bus.rf_wd, e.wd);
        last_rd = e.rd;
        last_wd = e.wd;
        $display("wb cyc=%0d we=%0b rd=x%0d wd=0x%08h", cyc, bus.rf_we, bus.rf_rd, bus.rf_wd);
      end else begin
        chk("rf_we_idle", 32'(bus.rf_we), 32'd0);
        chk("rf_rd_hold", 32'(bus.rf_rd), 32'(last_rd));
        chk("rf_wd_hold", bus.rf_wd, last_wd);
      end
    end
  end

  int first_b;

  initial begin
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_rf_we",     32'(bus.rf_we),     32'd0);
    chk("reset_rf_rd",     32'(bus.rf_rd),     32'd0);
    chk("reset_rf_wd",     bus.rf_wd,          32'd0);
    chk("reset_busy_cnt",  32'(bus.busy_cnt),  32'd0);
    chk("reset_a_ready",   32'(bus.a_ready),   32'd1);
    chk("reset_b_ready",   32'(bus.b_ready),   32'd1);
    chk("reset_iss_stall", 32'(bus.iss_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU write, then ALU write to x0 (accepted, dropped).
    step(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h0BADF00D, 0, 0, '0);
    idle(1);

    // Long load to x7, RAW stall, release one cycle after the B handshake.
    step(1, 1, 2, 7, 1, 0, 0, '0, 0, 0, '0);
    idle(1);
    chk("busy_cnt_after_x7", 32'(bus.busy_cnt), 32'd1);
    step(1, 7, 0, 8, 0, 0, 0, '0, 0, 0, '0);
    step(1, 7, 0, 8, 0, 0, 0, '0, 1, 7, 32'h1234);
    step(1, 7, 0, 8, 0, 0, 0, '0, 0, 0, '0);
    chk("raw_released", 32'(bus.iss_stall), 32'd0);
    idle(1);

    // Starvation: A held high, B waits exactly LIMIT cycles.
    first_b = -1;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 0, 1, i + 1, $urandom, 1, 12, $urandom);
      if (first_b < 0 && bus.b_ready) first_b = i;
    end
    chk("starve_grant_cycle", 32'(first_b), 32'(LIMIT));
    idle(1);

    // WAW on x3: stall persists until the cycle after the B handshake.
    step(1, 1, 2, 3, 1, 0, 0, '0, 0, 0, '0);
    step(1, 4, 6, 3, 1, 0, 0, '0, 0, 0, '0);
    step(1, 4, 6, 3, 1, 0, 0, '0, 0, 0, '0);
    step(1, 4, 6, 3, 1, 0, 0, '0, 1, 3, 32'hCAFE0003);
    step(1, 4, 6, 3, 1, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, 0, '0, 1, 3, 32'h33333333);
    idle(1);

    // Simultaneous A(x9) and B(x10): back-to-back writes, A first.
    step(0, 0, 0, 0, 0, 1, 9, 32'h99999999, 1, 10, 32'hAAAAAAAA);
    step(0, 0, 0, 0, 0, 0, 0, '0, 1, 10, 32'hAAAAAAAA);
    chk("simul_rf_rd_first", 32'(bus.rf_rd), 32'd9);
    idle(2);

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
           int'($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)), $urandom);
    end

    // Build up busy state, then reset in the middle of a write.
    step(1, 0, 0, 13, 1, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 5, 32'h55AA55AA, 0, 0, '0);
    @(posedge clk);
    #1;
    chk("pre_reset_rf_we", 32'(bus.rf_we), 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    drive_idle();
    #1;
    chk("midreset_rf_we",    32'(bus.rf_we),    32'd0);
    chk("midreset_rf_rd",    32'(bus.rf_rd),    32'd0);
    chk("midreset_rf_wd",    bus.rf_wd,         32'd0);
    chk("midreset_busy_cnt", 32'(bus.busy_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 13, 0, 13, 0, 0, 0, '0, 0, 0, '0);
    chk("post_reset_a_ready", 32'(bus.a_ready), 32'd1);
    idle(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
